fetch_stage: RTL



---
 rtl/rv_pkg.sv | 28 ++
 rtl/if_id_reg.sv | 28 ++
 rtl/fetch_stage.sv | 92 +++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared pipeline types and constants for the 5-stage core.
package rv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] instruction;
    logic            valid;
  } if_id_t;

  // Bubble keeps pc_plus4 == pc + 4 so the link value stays consistent.
  localparam if_id_t IF_ID_BUBBLE = '{
    pc:          '0,
    pc_plus4:    32'd4,
    instruction: NOP_INSTR,
    valid:       1'b0
  };

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register with load, hold and bubble controls; also the template for ID/EX.
module if_id_reg
  import rv_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   i_load,
  input  logic   i_bubble,
  input  if_id_t i_d,
  output if_id_t o_q
);

  if_id_t r_q;

  // Bubble wins over load; neither asserted means hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= IF_ID_BUBBLE;
    end else if (i_bubble) begin
      r_q <= IF_ID_BUBBLE;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fills IF/ID, handles stall, redirect and end-of-image halt.
module fetch_stage
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NUM_INST = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  input  logic [31:0] instruction,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic [31:0] if_id_instruction,
  output logic        if_id_valid,
  output logic        misalign_err,
  output logic        halted,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] END_PC = 32'(NUM_INST * 4);

  logic [31:0]  r_pc;
  logic [31:0]  r_fetch_count;
  logic         r_misalign;
  fetch_state_t r_state;

  logic [31:0]  w_pc_plus4;
  logic [31:0]  w_target_aligned;
  logic         w_advance;
  logic         w_bubble;
  if_id_t       w_if_id_d;
  if_id_t       w_if_id_q;

  assign w_pc_plus4       = r_pc + 32'd4;
  assign w_target_aligned = {branch_target[31:2], 2'b00};

  // Redirect beats stall; HALT drains IF/ID with bubbles unless stalled.
  assign w_advance = !branch_taken && !stall && (r_state == RUN);
  assign w_bubble  = branch_taken || (!stall && (r_state == HALT));

  assign w_if_id_d = '{
    pc:          r_pc,
    pc_plus4:    w_pc_plus4,
    instruction: instruction,
    valid:       1'b1
  };

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_fetch_count <= '0;
      r_misalign    <= 1'b0;
      r_state       <= RUN;
    end else begin
      r_misalign <= branch_taken && (branch_target[1:0] != 2'b00);
      if (branch_taken) begin
        r_pc    <= w_target_aligned;
        r_state <= (w_target_aligned >= END_PC) ? HALT : RUN;
      end else if (w_advance) begin
        r_pc          <= w_pc_plus4;
        r_fetch_count <= r_fetch_count + 32'd1;
        // The last word is still delivered; halt on the same edge.
        if (w_pc_plus4 == END_PC) begin
          r_state <= HALT;
        end
      end
    end
  end

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_advance),
    .i_bubble (w_bubble),
    .i_d      (w_if_id_d),
    .o_q      (w_if_id_q)
  );

  assign pc                = r_pc;
  assign if_id_pc          = w_if_id_q.pc;
  assign if_id_pc_plus4    = w_if_id_q.pc_plus4;
  assign if_id_instruction = w_if_id_q.instruction;
  assign if_id_valid       = w_if_id_q.valid;
  assign misalign_err      = r_misalign;
  assign halted            = (r_state == HALT);
  assign fetch_count       = r_fetch_count;

endmodule
